calc_entry_sequencer: RTL and testbench

- Top-level controller for the two-operand calculator path.
- Debounces the entry pushbutton and sequences digit capture from the 4-bit dipswitch into operand A, then operand B.
- Launches the arithmetic unit with a start/done handshake, guarded by a timeout, and holds the result for the display.
- Sits between the raw board I/O and the arithmetic/display blocks.

---
 rtl/calc_entry_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_calc_entry_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_sequencer.sv
// calc_entry_sequencer
//   Top-level controller for the two-operand calculator path. It debounces the
//   entry pushbutton and captures dipswitch digits into operand A and then
//   operand B. It then launches the arithmetic unit with a start/done handshake
//   that is guarded by a timeout, and holds the result for the display.
//
//   state      | meaning
//   -----------+-------------------------------------------------
//   IDLE  (0)  | waiting for the first digit of a new calculation
//   ENTER_A(1) | collecting digits of operand A
//   ENTER_B(2) | collecting digits of operand B
//   START (3)  | one-cycle launch of the arithmetic unit
//   WAIT_DONE(4)| waiting for op_done, bounded by TIMEOUT_CYCLES
//   SHOW  (5)  | result latched and valid for the display
//   ERR   (6)  | arithmetic unit timed out; a press returns to IDLE
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   sw            dipswitch digit, MSB first
//   btn_raw       raw asynchronous, bouncy entry pushbutton
//   op_done       one-cycle completion pulse from the arithmetic unit
//   op_result     arithmetic result, valid with op_done
//   operand_a/b   captured operands
//   op_start      one-cycle launch pulse
//   result        latched result
//   result_valid  high in SHOW; busy high in START/WAIT_DONE
//   timeout_err   high in ERR
//   digit_err     one-cycle pulse when a non-BCD digit is rejected
//   state_code    current state encoding
//   digit_idx     digits captured so far in the current operand
//
// Build option: CALC_BCD_CHECK_EN rejects digits above 9 in the entry states.
// Without it, every nibble is accepted and digit_err is tied low.

module calc_entry_sequencer #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int NUM_DIGITS      = 3,
    parameter int DIGIT_W         = 4,
    parameter int RES_W           = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DIGIT_W-1:0]                sw,
    input  logic                              btn_raw,
    input  logic                              op_done,
    input  logic [RES_W-1:0]                  op_result,
    output logic [NUM_DIGITS*DIGIT_W-1:0]     operand_a,
    output logic [NUM_DIGITS*DIGIT_W-1:0]     operand_b,
    output logic                              op_start,
    output logic [RES_W-1:0]                  result,
    output logic                              result_valid,
    output logic                              busy,
    output logic                              timeout_err,
    output logic                              digit_err,
    output logic [2:0]                        state_code,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_idx
);

    localparam int OP_W  = NUM_DIGITS * DIGIT_W;
    localparam int IDX_W = $clog2(NUM_DIGITS + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ENTER_A   = 3'd1,
        S_ENTER_B   = 3'd2,
        S_START     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_SHOW      = 3'd5,
        S_ERR       = 3'd6
    } state_t;

    state_t             state, state_nxt;
    logic [OP_W-1:0]    a_nxt, b_nxt;
    logic [RES_W-1:0]   res_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic [TO_W-1:0]    to_cnt, to_cnt_nxt;

    logic               btn_meta, btn_sync, btn_clean, btn_clean_d;
    logic [DB_W-1:0]    db_cnt;
    logic               press;
    logic               digit_bad;

    // Button path: 2-FF synchronizer, then a counter that must see the new
    // level for DEBOUNCE_CYCLES consecutive cycles before the clean level flips.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta    <= 1'b0;
            btn_sync    <= 1'b0;
            btn_clean   <= 1'b0;
            btn_clean_d <= 1'b0;
            db_cnt      <= '0;
        end else begin
            btn_meta    <= btn_raw;
            btn_sync    <= btn_meta;
            btn_clean_d <= btn_clean;
            if (btn_sync == btn_clean) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
                btn_clean <= btn_sync;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = btn_clean & ~btn_clean_d;

`ifdef CALC_BCD_CHECK_EN
    assign digit_bad = (sw > DIGIT_W'(9));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_err <= 1'b0;
        end else begin
            digit_err <= press && digit_bad &&
                         (state inside {S_IDLE, S_SHOW, S_ENTER_A, S_ENTER_B});
        end
    end
`else
    assign digit_bad = 1'b0;
    assign digit_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            operand_a <= '0;
            operand_b <= '0;
            result    <= '0;
            digit_idx <= '0;
            to_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            operand_a <= a_nxt;
            operand_b <= b_nxt;
            result    <= res_nxt;
            digit_idx <= idx_nxt;
            to_cnt    <= to_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        a_nxt      = operand_a;
        b_nxt      = operand_b;
        res_nxt    = result;
        idx_nxt    = digit_idx;
        to_cnt_nxt = to_cnt;
        case (state)
            S_IDLE, S_SHOW: begin
                if (press && !digit_bad) begin
                    a_nxt   = OP_W'(sw);
                    b_nxt   = '0;
                    res_nxt = '0;
                    if (NUM_DIGITS == 1) begin
                        state_nxt = S_ENTER_B;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = S_ENTER_A;
                        idx_nxt   = IDX_W'(1);
                    end
                end
            end
            S_ENTER_A: begin
                if (press && !digit_bad) begin
                    a_nxt = (operand_a << DIGIT_W) | OP_W'(sw);
                    if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                        state_nxt = S_ENTER_B;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = digit_idx + 1'b1;
                    end
                end
            end
            S_ENTER_B: begin
                if (press && !digit_bad) begin
                    b_nxt = (operand_b << DIGIT_W) | OP_W'(sw);
                    if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                        state_nxt = S_START;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = digit_idx + 1'b1;
                    end
                end
            end
            S_START: begin
                state_nxt  = S_WAIT_DONE;
                to_cnt_nxt = '0;
            end
            S_WAIT_DONE: begin
                // op_done takes priority over a coincident timeout
                if (op_done) begin
                    res_nxt   = op_result;
                    state_nxt = S_SHOW;
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = S_ERR;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            S_ERR: begin
                // the digit on the recovering press is discarded
                if (press) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign op_start     = (state == S_START);
    assign busy         = (state == S_START) || (state == S_WAIT_DONE);
    assign result_valid = (state == S_SHOW);
    assign timeout_err  = (state == S_ERR);
    assign state_code   = state;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
module tb_calc_entry_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sw = 4'd0;
    logic        btn_raw = 1'b0;
    logic        op_done = 1'b0;
    logic [15:0] op_result = 16'd0;
    logic [11:0] operand_a, operand_b;
    logic        op_start, result_valid, busy, timeout_err, digit_err;
    logic [15:0] result;
    logic [2:0]  state_code;
    logic [1:0]  digit_idx;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int derr_cnt = 0;
    int n;

    calc_entry_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .NUM_DIGITS(3),
        .DIGIT_W(4),
        .RES_W(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .btn_raw(btn_raw),
        .op_done(op_done),
        .op_result(op_result),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .op_start(op_start),
        .result(result),
        .result_valid(result_valid),
        .busy(busy),
        .timeout_err(timeout_err),
        .digit_err(digit_err),
        .state_code(state_code),
        .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (op_start)  start_cnt++;
        if (digit_err) derr_cnt++;
    endtask

    task automatic press(input logic [3:0] d);
        sw = d;
        btn_raw = 1'b1;
        repeat (12) tick();
        btn_raw = 1'b0;
        repeat (12) tick();
    endtask

    // holds the button until the launch pulse appears; the button stays high
    task automatic press_last(input logic [3:0] d);
        int k;
        sw = d;
        btn_raw = 1'b1;
        k = 0;
        while (!op_start && k < 30) begin
            tick();
            k++;
        end
        check("start_seen", {31'd0, op_start}, 32'd1);
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        check("rst_flags", {state_code, digit_idx, result_valid, busy, timeout_err, op_start, digit_err}, 32'd0);
        check("rst_ops", {operand_a, operand_b}, 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // 1: glitch rejected, debounce latency, no pulse on release
        sw = 4'd1;
        btn_raw = 1'b1; tick();
        btn_raw = 1'b0; tick();
        btn_raw = 1'b1; tick();
        btn_raw = 1'b0; tick();
        repeat (6) tick();
        check("glitch", state_code, 32'd0);
        btn_raw = 1'b1;
        repeat (7) tick();
        check("db_lat_pre", state_code, 32'd0);
        tick();
        check("db_lat", state_code, 32'd1);
        check("first_digit", {digit_idx, operand_a}, {18'd0, 2'd1, 12'h001});
        repeat (4) tick();
        btn_raw = 1'b0;
        repeat (12) tick();
        check("release", {state_code, digit_idx}, {27'd0, 3'd1, 2'd1});

        // 2: operand entry and launch
        press(4'd2);
        check("a_two", {state_code, digit_idx, operand_a}, {15'd0, 3'd1, 2'd2, 12'h012});
        press(4'd3);
        check("a_done", {state_code, digit_idx, operand_a}, {15'd0, 3'd2, 2'd0, 12'h123});
        press(4'd4);
        press(4'd5);
        check("b_two", {state_code, digit_idx, operand_b}, {15'd0, 3'd2, 2'd2, 12'h045});
        press_last(4'd6);
        check("start_state", {state_code, busy, operand_b}, {16'd0, 3'd3, 1'b1, 12'h456});
        tick();
        check("wait_state", {state_code, busy, op_start}, {27'd0, 3'd4, 1'b1, 1'b0});
        check("start_once", start_cnt, 32'd1);
        repeat (4) tick();
        op_result = 16'h0579;
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        op_result = 16'h0000;

        // 3: result held in SHOW, new press restarts
        check("show_result", result, 32'h0579);
        check("show_state", {state_code, result_valid, busy}, {27'd0, 3'd5, 1'b1, 1'b0});
        btn_raw = 1'b0;
        repeat (12) tick();
        check("show_hold", {state_code, result}, {13'd0, 3'd5, 16'h0579});
        press(4'd7);
        check("restart_ops", {operand_a, operand_b}, {8'd0, 12'h007, 12'h000});
        check("restart_state", {state_code, result_valid, result}, {12'd0, 3'd1, 1'b0, 16'h0000});

        // 4: timeout path
        press(4'd8);
        press(4'd9);
        check("a_789", operand_a, 32'h789);
        press(4'd1);
        press(4'd2);
        press_last(4'd3);
        tick();
        btn_raw = 1'b0;
        n = 0;
        while (state_code == 3'd4 && n < 60) begin
            n++;
            tick();
        end
        check("wait_cycles", n, 32'd16);
        check("err_state", {state_code, timeout_err, busy}, {27'd0, 3'd6, 1'b1, 1'b0});
        op_result = 16'hBEEF;
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        tick();
        check("err_ignore_done", {state_code, result}, {13'd0, 3'd6, 16'h0000});
        press(4'd5);
        check("err_to_idle", {state_code, timeout_err}, {28'd0, 3'd0, 1'b0});
        check("err_ops_kept", {operand_a, operand_b}, {8'd0, 12'h789, 12'h123});
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        tick();
        check("idle_ignore_done", {state_code, result_valid, result}, {12'd0, 3'd0, 1'b0, 16'h0000});

        // 5: digit validity
        press(4'd1);
        check("bcd_first", {state_code, digit_idx, operand_a}, {15'd0, 3'd1, 2'd1, 12'h001});
        derr_cnt = 0;
        press(4'hA);
`ifdef CALC_BCD_CHECK_EN
        check("bcd_reject_pulse", derr_cnt, 32'd1);
        check("bcd_reject_hold", {state_code, digit_idx, operand_a}, {15'd0, 3'd1, 2'd1, 12'h001});
        press(4'd9);
        check("bcd_accept", {state_code, digit_idx, operand_a}, {15'd0, 3'd1, 2'd2, 12'h019});
        press(4'd2);
        check("bcd_a_done", {state_code, operand_a}, {17'd0, 3'd2, 12'h192});
`else
        check("nibble_no_err", derr_cnt, 32'd0);
        check("nibble_accept", {state_code, digit_idx, operand_a}, {15'd0, 3'd1, 2'd2, 12'h01A});
        press(4'd9);
        check("nibble_a_done", {state_code, digit_idx, operand_a}, {15'd0, 3'd2, 2'd0, 12'h1A9});
`endif

        // 6: reset during WAIT_DONE aborts; later op_done ignored
        press(4'd4);
        press(4'd5);
        press_last(4'd6);
        btn_raw = 1'b0;
        tick();
        tick();
        check("pre_rst_wait", state_code, 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_flags", {state_code, digit_idx, result_valid, busy, timeout_err, op_start, digit_err}, 32'd0);
        check("mid_rst_ops", {operand_a, operand_b}, 32'd0);
        op_result = 16'h1234;
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        tick();
        check("post_rst_done", {state_code, result_valid, result}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
